// File: rtl/fetch_seq_if.sv
// fetch_seq_if: bus between the fetch sequencer (master) and the program ROM /
// instruction decoder (slave). Carries the bus cycle phase, the fetch address,
// the returned nibble and the decoder-facing fetch results and redirect.
interface fetch_seq_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [2:0]        cycle;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_nibble;
  logic [3:0]        opr;
  logic [3:0]        opa;
  logic              instr_valid;
  logic              word2;
  logic              two_word;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] pc;
  logic              sync;

  modport master (
    output cycle, rom_addr, opr, opa, instr_valid, word2, pc, sync,
    input  rom_nibble, two_word, jump_req, jump_addr
  );

  modport slave (
    input  cycle, rom_addr, opr, opa, instr_valid, word2, pc, sync,
    output rom_nibble, two_word, jump_req, jump_addr
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer. Runs the 8-phase bus cycle
// (A1..X3 = 0..7), presents the fetch address for the whole bus cycle,
// captures OPR/OPA in M1/M2, advances the PC, handles jump redirection and
// two-word instruction tracking.
// Optional breakpoint/halt logic is enabled by defining FETCH_BRKPT_EN.
module fetch_seq #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
`ifdef FETCH_BRKPT_EN
  input  logic              i_bp_en,
  input  logic [ADDR_W-1:0] i_bp_addr,
  output logic              o_halted,
`endif
  fetch_seq_if.master       bus
);

  logic [2:0]        r_cycle,       w_cycle_d;
  logic [ADDR_W-1:0] r_pc,          w_pc_d;
  logic [ADDR_W-1:0] r_rom_addr,    w_rom_addr_d;
  logic [3:0]        r_opr,         w_opr_d;
  logic [3:0]        r_opa,         w_opa_d;
  logic              r_instr_valid, w_instr_valid_d;
  logic              r_word2,       w_word2_d;
  logic              r_sync,        w_sync_d;
  logic              r_pending,     w_pending_d;
  logic              w_stall;

`ifdef FETCH_BRKPT_EN
  logic r_halted, w_halted_d;
  assign w_stall  = !i_run || r_halted;
  assign o_halted = r_halted;
`else
  assign w_stall = !i_run;
`endif

  // Next-state: phase counter plus per-phase capture / PC / redirect actions.
  always_comb begin
    w_cycle_d       = r_cycle;
    w_pc_d          = r_pc;
    w_rom_addr_d    = r_rom_addr;
    w_opr_d         = r_opr;
    w_opa_d         = r_opa;
    w_instr_valid_d = r_instr_valid;
    w_word2_d       = r_word2;
    w_sync_d        = r_sync;
    w_pending_d     = r_pending;

    // Halting only takes effect on the A1 boundary; a started bus cycle completes.
    if (!(r_cycle == 3'd0 && w_stall)) begin
      w_cycle_d = r_cycle + 3'd1;
    end

    unique case (r_cycle)
      3'd3: w_opr_d = bus.rom_nibble;
      3'd4: begin
        w_opa_d         = bus.rom_nibble;
        w_instr_valid_d = 1'b1;
        w_pc_d          = r_pc + ADDR_W'(1);
      end
      3'd5: begin
        w_instr_valid_d = 1'b0;
        // The second word of a two-word instruction never starts another pair.
        w_pending_d     = r_word2 ? 1'b0 : bus.two_word;
      end
      3'd6: w_sync_d = 1'b1;
      3'd7: begin
        w_sync_d  = 1'b0;
        w_word2_d = r_pending;
        // Jump overrides the increment already applied in M2.
        if (bus.jump_req) begin
          w_pc_d       = bus.jump_addr;
          w_rom_addr_d = bus.jump_addr;
        end else begin
          w_rom_addr_d = r_pc;
        end
      end
      default: ;
    endcase

`ifdef FETCH_BRKPT_EN
    w_halted_d = r_halted;
    if (r_halted && !i_bp_en) begin
      w_halted_d = 1'b0;
    end
    if (r_cycle == 3'd7 && i_bp_en && w_rom_addr_d == i_bp_addr) begin
      w_halted_d = 1'b1;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle       <= 3'd0;
      r_pc          <= RESET_PC;
      r_rom_addr    <= RESET_PC;
      r_opr         <= 4'h0;
      r_opa         <= 4'h0;
      r_instr_valid <= 1'b0;
      r_word2       <= 1'b0;
      r_sync        <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_cycle       <= w_cycle_d;
      r_pc          <= w_pc_d;
      r_rom_addr    <= w_rom_addr_d;
      r_opr         <= w_opr_d;
      r_opa         <= w_opa_d;
      r_instr_valid <= w_instr_valid_d;
      r_word2       <= w_word2_d;
      r_sync        <= w_sync_d;
      r_pending     <= w_pending_d;
    end
  end

`ifdef FETCH_BRKPT_EN
  // Breakpoint halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= w_halted_d;
    end
  end
`endif

  assign bus.cycle       = r_cycle;
  assign bus.rom_addr    = r_rom_addr;
  assign bus.opr         = r_opr;
  assign bus.opa         = r_opa;
  assign bus.instr_valid = r_instr_valid;
  assign bus.word2       = r_word2;
  assign bus.pc          = r_pc;
  assign bus.sync        = r_sync;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- CPU-side instruction fetch sequencer; the initiator paired with the program ROM.
- Generates the 8-phase bus cycle count (A1,A2,A3,M1,M2,X1,X2,X3 = 0..7) and presents the 12-bit fetch address.
- Captures the two nibbles the ROM returns in M1/M2 as OPR/OPA.
- Maintains the program counter, jump redirection and two-word instruction tracking, then hands each fetched word to the decoder.

Parameters:
- ADDR_W, 12, program address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 12'h000, PC and fetch address value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = sequence bus cycles; 0 = halt at A1 boundary.
- cycle  out  3  current phase 0..7; drives ROM cycle input.
- rom_addr  out  ADDR_W  fetch address to ROM; stable for whole bus cycle.
- rom_nibble  in  4  ROM nibble; valid during cycle 3 (high) and 4 (low).
- opr  out  4  captured upper nibble.
- opa  out  4  captured lower nibble.
- instr_valid  out  1  one-clock pulse, high during cycle 5 (X1).
- word2  out  1  1 = current opr/opa is the second word of a two-word instruction.
- two_word  in  1  decoder flag, sampled during X1 when instr_valid=1 and word2=0.
- jump_req  in  1  redirect request, sampled at edge leaving X3.
- jump_addr  in  ADDR_W  redirect target.
- pc  out  ADDR_W  address of next word to fetch.
- sync  out  1  high during cycle 7 (X3).

Behaviour:
- Reset (async, rst_n=0) sets:
  - cycle=0, pc=RESET_PC, rom_addr=RESET_PC, opr=opa=0.
  - instr_valid=0, word2=0, sync=0, internal two_word pending flag=0.
- Cycle counter:
  - While active, cycle increments 0→7 and wraps 7→0 each clock.
  - When run=0 and cycle=0, counter holds at 0; no capture, no pc change.
  - When run falls mid-cycle, the current bus cycle completes through X3, then holds at A1.
  - When run rises while holding, the next edge moves cycle to 1.
- ROM read is synchronous, so rom_addr must be stable from A1. rom_addr is loaded only at the edge leaving X3 (or by reset) and never changes inside a bus cycle.
- Edge with cycle=3: opr <= rom_nibble.
- Edge with cycle=4:
  - opa <= rom_nibble; instr_valid <= 1.
  - pc <= pc+1, wrapping 12'hFFF→12'h000.
- Edge with cycle=5:
  - instr_valid <= 0.
  - If word2=0, pending <= two_word; else pending <= 0.
- Edge with cycle=6: sync <= 1.
- Edge with cycle=7:
  - sync <= 0; word2 <= pending.
  - If jump_req=1: pc <= jump_addr and rom_addr <= jump_addr.
  - Else: rom_addr <= pc.
- Jump has priority over sequential increment. The increment already applied at M2 is discarded.
- Jump in the same bus cycle that flagged two_word: word2 still sets. The second word is fetched from jump_addr (decoder is responsible for not doing this).
- jump_req outside cycle 7 is ignored; no latching.
- opr/opa hold their value from M2 until the next M1/M2.
- Reset asserted mid-cycle aborts immediately; the first fetch after release is from RESET_PC with word2=0.

Optional Feature:
- Macro FETCH_BRKPT_EN.
- When defined, adds ports:
  - bp_en in 1
  - bp_addr in ADDR_W
  - halted out 1 (reset 0)
- Breakpoint trigger: at the edge leaving X3, if bp_en=1 and the new rom_addr equals bp_addr, halted <= 1.
- While halted=1, the counter holds at 0 exactly as with run=0.
- halted clears at the first edge where bp_en=0. Fetch then proceeds from the held address.
- When undefined: no extra ports; behaviour as above.

Test Plan:
- Reset, run=1, ROM[0]=8'hD5 → cycle=3 edge opr=4'hD; cycle=4 edge opa=4'h5; instr_valid high one clock in cycle 5; pc=1; rom_addr=1 at next A1.
- ROM[1]=8'h40, two_word=1 at X1, ROM[2]=8'h37 → second fetch at addr 2 with word2=1, opr=3, opa=7; word2=0 on third fetch.
- jump_req=1, jump_addr=12'h123 held in X3 → next A1 rom_addr=12'h123, pc=12'h123; jump_req pulsed in cycle 2 only → ignored, rom_addr=pc+1.
- PC at 12'hFFF, sequential fetch → pc and next rom_addr = 12'h000.
- run dropped in cycle 2 → counter runs to 7, holds at 0, rom_addr unchanged, no instr_valid; run raised → resumes fetch at same address.
- rst_n pulsed low in cycle 4 → all outputs at reset values immediately; after release fetch at RESET_PC. With FETCH_BRKPT_EN, bp_addr=12'h002 → halted=1 at A1 with rom_addr=2; bp_en=0 → fetch of addr 2 completes.
